// File: rtl/lab3_bcd_serial_add_sub.sv
// lab3_bcd_serial_add_sub: digit-serial 3-digit BCD add/subtract, sign+magnitude result.
// Define BCD_CHECK_EN to reject operands containing a digit > 9 (err=1, done one cycle after accept).
module lab3_bcd_serial_add_sub (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        mode,
   input  logic [11:0] BCD_X,
   input  logic [11:0] BCD_Y,
   output logic        busy,
   output logic        done,
   output logic [11:0] BCD_R,
   output logic        kout,
   output logic        err
);
   typedef enum logic [1:0] {IDLE, ADD, COMP, DONE} state_t;
   state_t state;
   logic [11:0] x, y;
   logic m, carry, cout;
   logic [1:0] idx;
   logic [3:0] xd, yd, rd, a, b, digit;
   logic [4:0] s;
   always_comb begin
      xd = x[{idx, 2'b00} +: 4];
      yd = y[{idx, 2'b00} +: 4];
      rd = BCD_R[{idx, 2'b00} +: 4];
      a = state == COMP ? 4'd9 - rd : xd;
      b = state == COMP ? 4'd0 : (m ? 4'd9 - yd : yd);
      s = {1'b0, a} + {1'b0, b} + {4'b0, carry};
      cout = s > 5'd9;
      digit = cout ? s[3:0] + 4'd6 : s[3:0];
   end
`ifdef BCD_CHECK_EN
   logic bad;
   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < 3; i++)
         bad = bad | (BCD_X[4*i +: 4] > 4'd9) | (BCD_Y[4*i +: 4] > 4'd9);
   end
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy <= 1'b0;
         done <= 1'b0;
         BCD_R <= 12'h000;
         kout <= 1'b0;
         err <= 1'b0;
         idx <= 2'd0;
         carry <= 1'b0;
         x <= 12'h000;
         y <= 12'h000;
         m <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               x <= BCD_X;
               y <= BCD_Y;
               m <= mode;
               idx <= 2'd0;
               carry <= mode;
               busy <= 1'b1;
`ifdef BCD_CHECK_EN
               if (bad) begin
                  state <= DONE;
                  done <= 1'b1;
                  err <= 1'b1;
                  BCD_R <= 12'h000;
                  kout <= 1'b0;
               end else
                  state <= ADD;
`else
               state <= ADD;
`endif
            end
            ADD: begin
               BCD_R[{idx, 2'b00} +: 4] <= digit;
               carry <= cout;
               idx <= idx + 2'd1;
               if (idx == 2'd2) begin
                  idx <= 2'd0;
                  kout <= m ? ~cout : cout;
                  // a subtraction without final carry borrowed: re-complement the result
                  if (m && !cout) begin
                     carry <= 1'b1;
                     state <= COMP;
                  end else begin
                     state <= DONE;
                     done <= 1'b1;
                  end
               end
            end
            COMP: begin
               BCD_R[{idx, 2'b00} +: 4] <= digit;
               carry <= cout;
               idx <= idx + 2'd1;
               if (idx == 2'd2) begin
                  idx <= 2'd0;
                  state <= DONE;
                  done <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               done <= 1'b0;
               busy <= 1'b0;
               err <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lab3_bcd_serial_add_sub.sv
// tb_lab3_bcd_serial_add_sub: randomized scoreboard bench with a decimal-arithmetic reference model.
module tb_lab3_bcd_serial_add_sub;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
   logic [11:0] BCD_X = 12'h000, BCD_Y = 12'h000;
   logic busy, done, kout, err;
   logic [11:0] BCD_R;
   int vec = 0, miss = 0, cyc = 0;
   typedef struct {int r; int k; int e; int lat; int sc; bit cr;} exp_t;
   exp_t q[$];

   lab3_bcd_serial_add_sub dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .BCD_X(BCD_X), .BCD_Y(BCD_Y),
      .busy(busy), .done(done), .BCD_R(BCD_R), .kout(kout), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string n, input int act, input int exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   function automatic int dec(input logic [11:0] v);
      return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [11:0] enc(input int v);
      return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic bit bad_digit(input logic [11:0] bx, input logic [11:0] by);
      for (int i = 0; i < 3; i++)
         if (bx[4*i +: 4] > 4'd9 || by[4*i +: 4] > 4'd9) return 1'b1;
      return 1'b0;
   endfunction

   function automatic exp_t model(input logic [11:0] bx, input logic [11:0] by, input logic md);
      exp_t e;
      int d;
      e.cr = 1'b1;
      e.e = 0;
      if (md) begin
         d = dec(bx) - dec(by);
         e.k = d < 0 ? 1 : 0;
         e.r = int'(enc(d < 0 ? -d : d));
         e.lat = d < 0 ? 7 : 4;
      end else begin
         d = dec(bx) + dec(by);
         e.k = d >= 1000 ? 1 : 0;
         e.r = int'(enc(d % 1000));
         e.lat = 4;
      end
      if (bad_digit(bx, by)) begin
`ifdef BCD_CHECK_EN
         e.e = 1; e.r = 0; e.k = 0; e.lat = 1;
`else
         e.cr = 1'b0;
         e.lat = 4;
`endif
      end
      return e;
   endfunction

   // called at a negedge; returns at the negedge after the accepting edge
   task automatic op(input logic [11:0] bx, input logic [11:0] by, input logic md, input bit push);
      exp_t e;
      int t = 0;
      while (busy && t < 100) begin @(negedge clk); t++; end
      if (busy) chk("idle_timeout", 1, 0);
      BCD_X = bx; BCD_Y = by; mode = md; start = 1'b1;
      if (push) begin
         e = model(bx, by, md);
         e.sc = cyc + 1;
         q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_reset_values();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_BCD_R", BCD_R, 0);
      chk("rst_kout", kout, 0);
      chk("rst_err", err, 0);
   endtask

   task automatic drain();
      int t = 0;
      while ((q.size() != 0 || busy) && t < 200) begin @(negedge clk); t++; end
      if (q.size() != 0) begin
         chk("drain_timeout", q.size(), 0);
         q.delete();
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && err && !done) chk("err_outside_done", err, 0);
      if (rst_n && done) begin
         if (q.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = q.pop_front();
            chk("latency", cyc - e.sc + 1, e.lat);
            if (e.cr) chk("BCD_R", BCD_R, e.r);
            if (e.cr) chk("kout", kout, e.k);
            chk("err", err, e.e);
         end
      end
   end

   initial begin
      logic [11:0] rx, ry;
      repeat (3) @(negedge clk);
      check_reset_values();
      rst_n = 1'b1;
      @(negedge clk);
      op(enc(123), enc(456), 1'b0, 1'b1);
      op(enc(999), enc(1), 1'b0, 1'b1);
      op(enc(500), enc(123), 1'b1, 1'b1);
      op(enc(0), enc(0), 1'b1, 1'b1);
      op(enc(123), enc(500), 1'b1, 1'b1);
      op(enc(1), enc(999), 1'b1, 1'b1);
      op(enc(999), enc(999), 1'b0, 1'b1);
      // a start pulse during an operation must be dropped
      op(enc(321), enc(654), 1'b1, 1'b1);
      @(negedge clk);
      BCD_X = enc(777); BCD_Y = enc(111); mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         rx = enc(int'($urandom_range(0, 999)));
         ry = enc(int'($urandom_range(0, 999)));
         op(rx, ry, 1'($urandom_range(0, 1)), 1'b1);
      end
      op(12'h1A3, enc(0), 1'b0, 1'b1);
      drain();
      // reset during the complement pass of a negative subtract
      op(enc(123), enc(500), 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1 check_reset_values();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("post_reset_idle", busy, 0);
      op(enc(42), enc(58), 1'b0, 1'b1);
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
